// File: rtl/apb_master_arb_if.sv
// Request/response handshakes for both requesters plus the shared APB bus.
// The master modport is the arbiter's view; the slave modport is the environment's view.
interface apb_master_arb_if #(
  parameter int AWIDTH = 4,
  parameter int DWIDTH = 8
);
  logic              req0_valid, req0_write, req0_ready;
  logic [AWIDTH-1:0] req0_addr;
  logic [DWIDTH-1:0] req0_wdata;
  logic              resp0_valid, resp0_err;
  logic [DWIDTH-1:0] resp0_rdata;

  logic              req1_valid, req1_write, req1_ready;
  logic [AWIDTH-1:0] req1_addr;
  logic [DWIDTH-1:0] req1_wdata;
  logic              resp1_valid, resp1_err;
  logic [DWIDTH-1:0] resp1_rdata;

  logic              PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
  logic [AWIDTH-1:0] PADDR;
  logic [DWIDTH-1:0] PWDATA, PRDATA;

  modport master (
    input  req0_valid, req0_write, req0_addr, req0_wdata,
    input  req1_valid, req1_write, req1_addr, req1_wdata,
    output req0_ready, resp0_valid, resp0_rdata, resp0_err,
    output req1_ready, resp1_valid, resp1_rdata, resp1_err,
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    output req0_valid, req0_write, req0_addr, req0_wdata,
    output req1_valid, req1_write, req1_addr, req1_wdata,
    input  req0_ready, resp0_valid, resp0_rdata, resp0_err,
    input  req1_ready, resp1_valid, resp1_rdata, resp1_err,
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_master_arb.sv
// Two-requester round-robin APB master with a PREADY watchdog.
// One transfer in flight; responses pulse back to the owning requester.
module apb_master_arb #(
  parameter int AWIDTH  = 4,
  parameter int DWIDTH  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic             PCLK,
  input  logic             PRESET,
  apb_master_arb_if.master bus
);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  state_t state, state_nxt;

  logic [1:0]             vld;
  logic                   last_grant, winner, accept, owner;
  logic                   done, timeout, fin;
  logic [CW-1:0]          wait_cnt;
  logic [1:0]             resp_vld, resp_err;
  logic [1:0][DWIDTH-1:0] resp_rdata;
  logic                   psel, penable, pwrite;
  logic [AWIDTH-1:0]      paddr;
  logic [DWIDTH-1:0]      pwdata;

  assign vld    = {bus.req1_valid, bus.req0_valid};
  // Contested: the requester not granted last time; otherwise whoever is valid.
  assign winner = (vld == 2'b11) ? ~last_grant : vld[1];
  assign accept = (state == IDLE) && !PRESET && (|vld);

  assign bus.req0_ready = accept && !winner;
  assign bus.req1_ready = accept &&  winner;

  assign done    = (state == ACCESS) && bus.PREADY;
  assign timeout = (state == ACCESS) && !bus.PREADY && (wait_cnt == CW'(TIMEOUT - 1));
  assign fin     = done || timeout;

  always_ff @(posedge PCLK) begin
    if (PRESET) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (fin) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      last_grant <= 1'b1;
      owner      <= 1'b0;
      wait_cnt   <= '0;
      psel       <= 1'b0;
      penable    <= 1'b0;
      pwrite     <= 1'b0;
      paddr      <= '0;
      pwdata     <= '0;
      resp_vld   <= '0;
      resp_err   <= '0;
      resp_rdata <= '0;
    end else begin
      resp_vld <= '0;
      case (state)
        IDLE: if (accept) begin
          psel       <= 1'b1;
          pwrite     <= winner ? bus.req1_write : bus.req0_write;
          paddr      <= winner ? bus.req1_addr  : bus.req0_addr;
          pwdata     <= winner ? bus.req1_wdata : bus.req0_wdata;
          owner      <= winner;
          last_grant <= winner;
          wait_cnt   <= '0;
        end
        SETUP: penable <= 1'b1;
        ACCESS: begin
          if (fin) begin
            psel    <= 1'b0;
            penable <= 1'b0;
            pwrite  <= 1'b0;
            resp_vld[owner]   <= 1'b1;
            // Timeouts and slave errors return zero data, as do writes.
            resp_err[owner]   <= bus.PREADY ? bus.PSLVERR : 1'b1;
            resp_rdata[owner] <= (bus.PREADY && !pwrite && !bus.PSLVERR) ? bus.PRDATA : '0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.PSEL        = psel;
  assign bus.PENABLE     = penable;
  assign bus.PWRITE      = pwrite;
  assign bus.PADDR       = paddr;
  assign bus.PWDATA      = pwdata;
  assign bus.resp0_valid = resp_vld[0];
  assign bus.resp0_err   = resp_err[0];
  assign bus.resp0_rdata = resp_rdata[0];
  assign bus.resp1_valid = resp_vld[1];
  assign bus.resp1_err   = resp_err[1];
  assign bus.resp1_rdata = resp_rdata[1];
endmodule

// File: tb/tb_apb_master_arb.sv
// Randomized bench for apb_master_arb: transaction-level model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_apb_master_arb;
  localparam int AW = 4, DW = 8, TO = 15;

  logic PCLK = 1'b0;
  logic PRESET;
  int   checks = 0, errors = 0;
  bit   chk_en = 1'b0;

  apb_master_arb_if #(.AWIDTH(AW), .DWIDTH(DW)) bus ();
  apb_master_arb #(.AWIDTH(AW), .DWIDTH(DW), .TIMEOUT(TO)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .bus(bus));

  always #5 PCLK = ~PCLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---- transaction-level model: one transfer record aged in cycles since accept ----
  bit          m_busy = 0, m_wr = 0, m_own = 0, m_last = 1;
  int          m_age = 0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0;
  logic [DW-1:0] m_rd [2] = '{8'h0, 8'h0};
  bit          m_re [2] = '{0, 0};
  bit          m_rv [2] = '{0, 0};

  function automatic bit exp_ready(input int n);
    bit v0, v1, mine, other;
    v0 = bus.req0_valid; v1 = bus.req1_valid;
    mine  = (n == 0) ? v0 : v1;
    other = (n == 0) ? v1 : v0;
    return !m_busy && !PRESET && mine && (!other || (m_last != n[0]));
  endfunction

  always @(posedge PCLK) begin
    bit r0, r1;
    r0 = exp_ready(0);
    r1 = exp_ready(1);
    m_rv[0] = 0; m_rv[1] = 0;
    if (PRESET) begin
      m_busy = 0; m_last = 1; m_addr = '0; m_wdata = '0; m_wr = 0;
      m_rd[0] = '0; m_rd[1] = '0; m_re[0] = 0; m_re[1] = 0;
    end else if (m_busy) begin
      if (m_age == 1) m_age = 2;
      else if (bus.PREADY) begin
        m_rv[m_own] = 1; m_re[m_own] = bus.PSLVERR;
        m_rd[m_own] = (!m_wr && !bus.PSLVERR) ? bus.PRDATA : '0;
        m_busy = 0;
      end else if (m_age - 1 == TO) begin
        m_rv[m_own] = 1; m_re[m_own] = 1; m_rd[m_own] = '0;
        m_busy = 0;
      end else m_age++;
    end else if (r0 || r1) begin
      m_own  = r1;
      m_last = r1;
      m_wr    = r1 ? bus.req1_write : bus.req0_write;
      m_addr  = r1 ? bus.req1_addr  : bus.req0_addr;
      m_wdata = r1 ? bus.req1_wdata : bus.req0_wdata;
      m_busy = 1; m_age = 1;
    end
  end

  always @(negedge PCLK) begin
    if (chk_en) begin
      chk("req0_ready",  bus.req0_ready,  exp_ready(0));
      chk("req1_ready",  bus.req1_ready,  exp_ready(1));
      chk("PSEL",        bus.PSEL,        m_busy);
      chk("PENABLE",     bus.PENABLE,     m_busy && m_age >= 2);
      chk("PWRITE",      bus.PWRITE,      m_busy && m_wr);
      chk("PADDR",       bus.PADDR,       m_addr);
      chk("PWDATA",      bus.PWDATA,      m_wdata);
      chk("resp0_valid", bus.resp0_valid, m_rv[0]);
      chk("resp1_valid", bus.resp1_valid, m_rv[1]);
      chk("resp0_rdata", bus.resp0_rdata, m_rd[0]);
      chk("resp1_rdata", bus.resp1_rdata, m_rd[1]);
      chk("resp0_err",   bus.resp0_err,   m_re[0]);
      chk("resp1_err",   bus.resp1_err,   m_re[1]);
    end
  end

  // ---- stimulus helpers: drive 1ns after the edge, sample on the falling edge ----
  task automatic cyc(); @(posedge PCLK); #1; endtask
  task automatic smp(); @(negedge PCLK); endtask

  task automatic req(input int n, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (n == 0) begin bus.req0_valid = 1; bus.req0_write = w; bus.req0_addr = a; bus.req0_wdata = d; end
    else        begin bus.req1_valid = 1; bus.req1_write = w; bus.req1_addr = a; bus.req1_wdata = d; end
  endtask

  task automatic drop(); bus.req0_valid = 0; bus.req1_valid = 0; endtask

  task automatic drain();
    drop(); bus.PREADY = 1; bus.PSLVERR = 0;
    repeat (5) cyc();
  endtask

  int  acc_i [$];
  int  acc_id[$];
  int  en, pc;
  bit  got;
  int  mode;

  initial begin
    PRESET = 1;
    bus.req0_valid = 1; bus.req0_write = 0; bus.req0_addr = '0; bus.req0_wdata = '0;
    bus.req1_valid = 0; bus.req1_write = 0; bus.req1_addr = '0; bus.req1_wdata = '0;
    bus.PRDATA = '0; bus.PREADY = 1; bus.PSLVERR = 0;
    cyc(); chk_en = 1;
    cyc(); smp();
    chk("rst_PSEL", bus.PSEL, 0);
    chk("rst_PADDR", bus.PADDR, 0);
    chk("rst_ready0", bus.req0_ready, 0);
    chk("rst_resp0_rdata", bus.resp0_rdata, 0);
    cyc(); PRESET = 0; drop();

    // zero-wait write from requester 0
    req(0, 1, 4'h2, 8'hA5); bus.PRDATA = 8'h99;
    smp(); chk("t1_ready0", bus.req0_ready, 1);
    cyc(); drop();
    smp(); chk("t1_setup_psel", bus.PSEL, 1); chk("t1_setup_pen", bus.PENABLE, 0);
    cyc(); smp();
    chk("t1_acc_pen", bus.PENABLE, 1); chk("t1_paddr", bus.PADDR, 4'h2);
    chk("t1_pwdata", bus.PWDATA, 8'hA5); chk("t1_pwrite", bus.PWRITE, 1);
    cyc(); smp();
    chk("t1_resp0_valid", bus.resp0_valid, 1); chk("t1_resp0_err", bus.resp0_err, 0);

    // read from requester 1
    cyc(); req(1, 0, 4'h5, 8'h00); bus.PRDATA = 8'h3C;
    cyc(); drop(); cyc(); cyc(); smp();
    chk("t2_resp1_valid", bus.resp1_valid, 1); chk("t2_resp1_rdata", bus.resp1_rdata, 8'h3C);
    chk("t2_resp0_valid", bus.resp0_valid, 0); chk("t2_resp0_rdata", bus.resp0_rdata, 0);

    // both valid continuously after reset: strict alternation, one accept every 3 cycles
    cyc(); PRESET = 1; req(0, 1, 4'h1, 8'h11); req(1, 1, 4'h2, 8'h22);
    cyc(); PRESET = 0;
    for (int i = 0; i < 13; i++) begin
      smp();
      if (bus.req0_ready) begin acc_i.push_back(i); acc_id.push_back(0); end
      if (bus.req1_ready) begin acc_i.push_back(i); acc_id.push_back(1); end
      cyc();
    end
    chk("t3_num_accepts", acc_i.size(), 5);
    for (int k = 0; k < acc_i.size() && k < 5; k++) begin
      chk("t3_accept_cycle", acc_i[k], 3 * k);
      chk("t3_accept_id", acc_id[k], k % 2);
    end
    drain();

    // three PREADY wait cycles
    req(0, 1, 4'h9, 8'h5A); bus.PREADY = 0;
    cyc(); drop();
    en = 0; got = 0;
    for (int k = 0; k < 40 && !got; k++) begin
      bus.PREADY = bus.PENABLE && (en >= 3);
      smp();
      if (bus.PENABLE) begin
        en++; chk("t4_paddr", bus.PADDR, 4'h9); chk("t4_pwdata", bus.PWDATA, 8'h5A);
      end
      if (bus.resp0_valid) got = 1;
      cyc();
    end
    chk("t4_penable_cycles", en, 4); chk("t4_resp_seen", got, 1);
    drain();

    // PREADY stuck low: watchdog terminates with error and zero data
    req(1, 0, 4'h3, 8'h00); bus.PREADY = 0; bus.PRDATA = 8'hFF;
    cyc(); drop();
    pc = 0; got = 0;
    for (int k = 0; k < 60 && !got; k++) begin
      smp();
      if (bus.PSEL) pc++;
      if (bus.resp1_valid) begin
        got = 1; chk("t5_err", bus.resp1_err, 1); chk("t5_rdata", bus.resp1_rdata, 0);
      end
      cyc();
    end
    chk("t5_psel_cycles", pc, 1 + TO); chk("t5_resp_seen", got, 1);
    drain();

    // slave error with PREADY
    req(0, 0, 4'h4, 8'h00); bus.PRDATA = 8'h77; bus.PSLVERR = 1;
    cyc(); drop(); cyc(); cyc(); smp();
    chk("t5b_resp0_valid", bus.resp0_valid, 1); chk("t5b_err", bus.resp0_err, 1);
    drain();

    // reset while in ACCESS drops the transfer silently
    req(0, 0, 4'h1, 8'h00); bus.PREADY = 0;
    cyc(); drop(); cyc(); cyc(); PRESET = 1;
    cyc(); PRESET = 0; smp();
    chk("t6_psel", bus.PSEL, 0); chk("t6_pen", bus.PENABLE, 0); chk("t6_resp", bus.resp0_valid, 0);
    cyc(); req(0, 1, 4'hC, 8'hC3); bus.PREADY = 1;
    cyc(); drop();
    got = 0;
    for (int k = 0; k < 10 && !got; k++) begin smp(); if (bus.resp0_valid) got = 1; cyc(); end
    chk("t6_next_completes", got, 1);

    // randomized traffic with varying slave behaviour
    mode = 0;
    for (int c = 0; c < 3000; c++) begin
      if (c % 100 == 0) mode = $urandom_range(0, 2);
      PRESET = ($urandom_range(0, 249) == 0);
      bus.req0_valid = ($urandom_range(0, 3) != 0);
      bus.req1_valid = ($urandom_range(0, 3) != 0);
      bus.req0_write = $urandom_range(0, 1); bus.req1_write = $urandom_range(0, 1);
      bus.req0_addr = AW'($urandom); bus.req1_addr = AW'($urandom);
      bus.req0_wdata = DW'($urandom); bus.req1_wdata = DW'($urandom);
      bus.PRDATA = DW'($urandom);
      bus.PSLVERR = ($urandom_range(0, 7) == 0);
      case (mode)
        0:       bus.PREADY = ($urandom_range(0, 9) != 0);
        1:       bus.PREADY = ($urandom_range(0, 9) < 3);
        default: bus.PREADY = 0;
      endcase
      cyc();
    end

    chk_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/apb_master_arb.md
# apb_master_arb

Two-port APB master that shares a single APB bus between two independent command requesters and drives the SETUP/ACCESS protocol toward the peripheral register file. Requesters hand over one transfer at a time through a valid/ready handshake. Each requester gets a one-cycle response pulse carrying read data and error status. Arbitration is round-robin, and a PREADY watchdog guarantees every accepted transfer terminates.

## Interface
- AWIDTH, 4, APB address width
- DWIDTH, 8, APB data width
- TIMEOUT, 15, max ACCESS cycles without PREADY before forced error termination (1..255)

Ports:
- PCLK  in  1  clock; all logic on rising edge
- PRESET  in  1  reset; one clock, reset synchronous, active-high
- req0_valid  in  1  requester 0 has a transfer
- req0_write  in  1  1 = write, 0 = read
- req0_addr  in  AWIDTH  target address
- req0_wdata  in  DWIDTH  write data
- req0_ready  out  1  transfer accepted this cycle (valid && ready)
- resp0_valid  out  1  one-cycle completion pulse
- resp0_rdata  out  DWIDTH  read data (0 for writes/errors)
- resp0_err  out  1  PSLVERR or timeout
- req1_*, resp1_*  same set for requester 1
- PSEL, PENABLE, PWRITE  out  1  APB control, registered
- PADDR  out  AWIDTH  registered
- PWDATA  out  DWIDTH  registered
- PRDATA  in  DWIDTH  slave read data
- PREADY  in  1  slave ready
- PSLVERR  in  1  slave error, sampled with PREADY

## Operation
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - Arbiter picks a winner among valid requests.
  - If only one is valid, that one wins.
  - If both are valid, the one not granted last wins.
  - reqN_ready = (state==IDLE) && winner==N; combinational, at most one high.
  - On accept: latch write/addr/wdata and owner id; update last_grant; go to SETUP.
- SETUP: PSEL=1, PENABLE=0, PADDR/PWRITE/PWDATA = latched values; always go to ACCESS.
- ACCESS:
  - PSEL=1, PENABLE=1; address, control and data held stable.
  - If PREADY=1: capture PRDATA (reads only; writes capture 0) and PSLVERR into the owner's resp registers; pulse respN_valid; go to IDLE.
  - If PREADY=0: increment wait counter (ceil(log2(TIMEOUT+1)) bits, cleared on entering SETUP).
  - If the counter reaches TIMEOUT with PREADY still 0: terminate with resp err=1, rdata=0; go to IDLE. Any later PREADY is ignored.
- APB outputs in IDLE: PSEL=0, PENABLE=0. PADDR/PWRITE/PWDATA hold their last values; PWRITE is forced 0 when PSEL=0.
- respN_rdata/respN_err hold until the next response to the same requester.
- A requester may drop valid before acceptance with no effect; requests are never queued internally.

## Timing
- Reset values:
  - state=IDLE, last_grant=1 (requester 0 wins first contest).
  - PSEL=PENABLE=PWRITE=0, PADDR=0, PWDATA=0.
  - resp*_valid=0, resp*_rdata=0, resp*_err=0, wait counter=0.
- Accept at edge T (IDLE) -> SETUP visible cycle T+1 -> ACCESS cycle T+2.
- Zero-wait slave: resp pulse in cycle T+3. Each PREADY wait cycle adds one cycle.
- State is IDLE in the same cycle as the resp pulse, so a new accept can occur in that cycle. Peak throughput is one transfer per 3 cycles.
- Timeout: ACCESS lasts exactly TIMEOUT cycles; resp err pulse in the next cycle.
- If PREADY=1 on the cycle the counter reaches TIMEOUT, PREADY wins (normal completion).
- PRESET asserted in any state: next cycle IDLE with all reset values. The in-flight transfer is dropped with no resp pulse. reqN_ready=0 while PRESET=1.
- PSLVERR and PRDATA are ignored unless PENABLE && PREADY.

## Test plan
- Req0 write addr 0x2 data 0xA5, PREADY tied 1 -> PSEL@T+1, PENABLE@T+2 with PADDR=2 PWDATA=A5 PWRITE=1, resp0_valid@T+3, resp0_err=0.
- Req1 read addr 0x5, slave PRDATA=0x3C -> resp1_valid pulse, resp1_rdata=0x3C, resp0 untouched.
- Both valid continuously after reset -> accepts alternate 0,1,0,1, one accept every 3 cycles, no idle gap.
- PREADY low 3 ACCESS cycles then high -> PENABLE held 4 cycles with PADDR/PWDATA stable, resp one cycle after PREADY.
- PREADY stuck 0, TIMEOUT=15 -> PSEL drops after 15 ACCESS cycles, resp err=1 rdata=0. PSLVERR=1 with PREADY -> err=1.
- PRESET during ACCESS -> PSEL=PENABLE=0 next cycle, no resp pulse; next request completes normally.
